// File: rtl/led_pattern_seq.sv
// led_pattern_seq: LED pattern register with rotate-left/right, ping-pong and hold modes, built-in prescaler and parallel load.
// Latency: a step or load appears one cycle after its terminal/load cycle; o_tick is high in that same cycle.
// Backpressure: none; i_enable low freezes the prescaler and i_load overrides a coincident step.
module led_pattern_seq #(
  parameter int NB_SHIFT = 4,
  parameter int NB_CNT   = 24
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic [1:0]          i_mode,
  input  logic [NB_CNT-1:0]   i_period,
  input  logic                i_load,
  input  logic [NB_SHIFT-1:0] i_load_data,
  output logic [NB_SHIFT-1:0] o_register,
  output logic                o_tick,
  output logic                o_dir
);

  typedef enum logic [1:0] {
    MODE_ROL  = 2'b00,
    MODE_ROR  = 2'b01,
    MODE_PING = 2'b10,
    MODE_HOLD = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam logic [NB_SHIFT-1:0] PAT_RESET = NB_SHIFT'(1);

  logic [NB_SHIFT-1:0] pat_q, pat_d;
  logic [NB_CNT-1:0]   cnt_q, cnt_d;
  dir_t                dir_q, dir_d;
  logic                tick_q, tick_d;
  mode_t               mode;
  logic                terminal;

  function automatic logic [NB_SHIFT-1:0] rol(input logic [NB_SHIFT-1:0] v);
    return {v[NB_SHIFT-2:0], v[NB_SHIFT-1]};
  endfunction

  function automatic logic [NB_SHIFT-1:0] ror(input logic [NB_SHIFT-1:0] v);
    return {v[0], v[NB_SHIFT-1:1]};
  endfunction

  assign mode = mode_t'(i_mode);
  // >= so that shrinking the period below the running count fires at once.
  assign terminal = i_enable && (cnt_q >= i_period);

  // State register; reset forces the single-LED pattern and clears everything else.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      pat_q  <= PAT_RESET;
      cnt_q  <= '0;
      dir_q  <= DIR_LEFT;
      tick_q <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      tick_q <= tick_d;
    end
  end

  // Next state: load beats step; step action chosen by the mode seen in the terminal cycle.
  always_comb begin
    pat_d  = pat_q;
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    tick_d = 1'b0;
    if (i_load) begin
      // A zero load would blank the bank forever, since rotation keeps popcount.
      pat_d = (i_load_data == '0) ? PAT_RESET : i_load_data;
      cnt_d = '0;
      dir_d = DIR_LEFT;
    end else if (terminal) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      case (mode)
        MODE_ROL: pat_d = rol(pat_q);
        MODE_ROR: pat_d = ror(pat_q);
        MODE_PING: begin
          if (dir_q == DIR_LEFT) begin
            if (pat_q[NB_SHIFT-1]) begin
              dir_d = DIR_RIGHT;
              pat_d = ror(pat_q);
            end else begin
              pat_d = rol(pat_q);
            end
          end else begin
            if (pat_q[0]) begin
              dir_d = DIR_LEFT;
              pat_d = rol(pat_q);
            end else begin
              pat_d = ror(pat_q);
            end
          end
        end
        default: pat_d = pat_q;
      endcase
    end else if (i_enable) begin
      cnt_d = cnt_q + NB_CNT'(1);
    end
  end

  assign o_register = pat_q;
  assign o_tick     = tick_q;
  assign o_dir      = dir_q;

endmodule

// File: doc/led_pattern_seq.md
Name: led_pattern_seq

Overview:
- Parametrised LED pattern sequencer, successor to the 4-bit rotate-left/right register.
- Adds a built-in programmable prescaler, so stepping no longer needs an external valid strobe.
- Adds ping-pong (bounce) and hold modes, a parallel load, and a direction status output.
- Drives the board LED bank directly from the top level; mode, period and load come from switches/VIO.

Parameters:
- NB_SHIFT, 4, pattern register width (>=2).
- NB_CNT, 24, prescaler counter width.

Ports:
- clock  in  1  system clock
- i_reset  in  1  asynchronous, active-low reset
- i_enable  in  1  high: prescaler runs; low: prescaler frozen, no steps
- i_mode  in  2  00 rotate left, 01 rotate right, 10 ping-pong, 11 hold
- i_period  in  NB_CNT  step interval minus 1, in clock cycles
- i_load  in  1  synchronous parallel load strobe
- i_load_data  in  NB_SHIFT  pattern to load
- o_register  out  NB_SHIFT  current pattern
- o_tick  out  1  one-cycle pulse, high in the cycle a new pattern first appears
- o_dir  out  1  ping-pong direction, 0 = left (toward MSB), 1 = right

Behaviour:
- Reset: i_reset is asynchronous, active-low; clock is clock. On reset:
  - o_register = {0...0,1}
  - prescaler count = 0
  - o_dir = 0
  - o_tick = 0
- Prescaler, while i_enable = 1:
  - Terminal when count >= i_period. On terminal: count <= 0 and step fires; otherwise count <= count + 1.
  - Using >= means a period reduced below the current count fires on the next cycle; the counter never free-runs to overflow.
  - i_period = 0 gives one step every cycle.
- i_enable = 0: count holds, no steps, o_tick = 0, register holds.
- Step timing: terminal detected in cycle N. At the clock edge ending N, the register updates and o_tick registers high, so both are visible in N+1. o_tick is high for exactly one cycle per step.
- Step action by i_mode, sampled in the terminal cycle:
  - 00: rotate left. reg <= {reg[NB_SHIFT-2:0], reg[NB_SHIFT-1]}.
  - 01: rotate right. reg <= {reg[0], reg[NB_SHIFT-1:1]}.
  - 10, o_dir = 0: if reg[NB_SHIFT-1] = 1, o_dir <= 1 and rotate right; else rotate left.
  - 10, o_dir = 1: if reg[0] = 1, o_dir <= 0 and rotate left; else rotate right.
  - 11: register holds. o_tick still pulses.
- o_dir changes only in mode 10 or on load. Leaving and re-entering mode 10 resumes with the stored o_dir.
- Load (i_load = 1), which has priority over a step in the same cycle:
  - reg <= i_load_data; if i_load_data = 0, reg <= {0...0,1} (the pattern is never blanked by load).
  - count <= 0, o_dir <= 0, o_tick <= 0.
  - Load acts regardless of i_enable.
- A mode change mid-interval does not reset the prescaler; the new mode applies at the next terminal.
- An all-zero register is unreachable: only reset and load write arbitrary values, and rotation preserves popcount.
- Reset asserted mid-interval or mid-load returns all state to reset values immediately, with no dependence on the clock.

Test Plan:
- Reset, i_mode=00, i_period=2, i_enable=1, NB_SHIFT=4 -> o_register 0001, 0010, 0100, 1000, 0001 at 3-cycle spacing; o_tick is a 1-cycle pulse coincident with each change.
- i_mode=01, i_period=0 from reset -> 1000, 0100, 0010, 0001 on consecutive cycles; o_tick held high continuously.
- i_mode=10, i_period=0 from reset:
  - -> 0010, 0100, 1000, 0100, 0010, 0001, 0010.
  - o_dir rises in the cycle 0100 follows 1000; o_dir falls when 0010 follows 0001.
  - Then load 1001 with o_dir=0 -> 1100 (o_dir=1), 0110, 0011, 0110 (o_dir=0).
- i_period=100, let count reach 50, then change i_period to 10 -> step on the next cycle, followed by 11-cycle spacing.
- i_load=1 with i_load_data=0000 coincident with a terminal cycle -> o_register=0001, no o_tick, count=0. Then i_enable=0 for 20 cycles -> no change and count frozen.
- Assert i_reset low asynchronously between clock edges in mode 10 with o_dir=1 and register 0100 -> o_register=0001, o_dir=0, o_tick=0 immediately, and held until release.
